// File: rtl/board_pkg.sv
// -----------------------------------------------------------------------------
// board_pkg
// Shared definitions for the board update sequencer:
//   - board geometry and packed-segment layout
//   - 2-bit cell codes written into the board memory
//   - sequencer state encoding
// -----------------------------------------------------------------------------
package board_pkg;

    localparam int GRID_BITS = 4;                // bits per coordinate
    localparam int SEG_W     = 8;                // {y[7:4], x[3:0]}
    localparam int MAX_SEG   = 225;              // longest snake
    localparam int SNAKE_W   = SEG_W * MAX_SEG;  // 1800-bit packed vector

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_FOOD  = 2'b01;
    localparam logic [1:0] CELL_BODY  = 2'b10;
    localparam logic [1:0] CELL_HEAD  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_SNAKE,
        ST_FOOD,
        ST_DONE
    } state_e;

endpackage

// File: rtl/board_update_ctrl_seg_unpack.sv
// -----------------------------------------------------------------------------
// seg_unpack
// Combinational selector: picks packed segment idx_i out of the wide snake
// vector and splits it into grid coordinates. Keeps the 225:1 mux in one place.
// Ports:
//   snake_i  in  packed segments, segment i at [8i +: 8]
//   idx_i    in  segment index (values >= MAX_SEG return 0)
//   x_o      out segment column
//   y_o      out segment row
// -----------------------------------------------------------------------------
module seg_unpack
    import board_pkg::*;
(
    input  logic [SNAKE_W-1:0]   snake_i,
    input  logic [7:0]           idx_i,
    output logic [GRID_BITS-1:0] x_o,
    output logic [GRID_BITS-1:0] y_o
);

    logic [10:0]      bit_off;
    logic [SEG_W-1:0] seg;

    always_comb begin
        bit_off = {idx_i, 3'b000};
        seg     = '0;
        // Guard keeps the part-select inside the 1800-bit vector.
        if (idx_i < 8'(MAX_SEG)) begin
            seg = snake_i[bit_off +: SEG_W];
        end
        x_o = seg[GRID_BITS-1:0];
        y_o = seg[SEG_W-1:GRID_BITS];
    end

endmodule

// File: rtl/board_update_ctrl.sv
// -----------------------------------------------------------------------------
// board_update_ctrl
// Per-tick sequencer owning the board memory write port. Each accepted tick
// clears all 256 cells, writes every snake segment (head first) and then the
// food cell, using a valid/ready handshake. Reports head self-collision and
// food-under-snake.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   tick           start-of-update pulse
//   snake_in       packed segments (held stable while busy)
//   seg_len        valid segment count (clamped to MAX_SEG)
//   xfood, yfood   food position
//   wr_en/wr_ready write handshake; wr_x/wr_y/wr_data write address and code
//   busy, done     update in progress / one-cycle completion pulse
//   self_hit       head equals a body segment
//   food_eaten     food equals a segment
//   overrun        sticky: tick seen while busy
// -----------------------------------------------------------------------------
module board_update_ctrl
    import board_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic [SNAKE_W-1:0]   snake_in,
    input  logic [7:0]           seg_len,
    input  logic [GRID_BITS-1:0] xfood,
    input  logic [GRID_BITS-1:0] yfood,
    output logic                 wr_en,
    input  logic                 wr_ready,
    output logic [GRID_BITS-1:0] wr_x,
    output logic [GRID_BITS-1:0] wr_y,
    output logic [1:0]           wr_data,
    output logic                 busy,
    output logic                 done,
    output logic                 self_hit,
    output logic                 food_eaten,
    output logic                 overrun
);

    state_e               state_q, state_d;
    logic [7:0]           cell_q, cell_d;
    logic [7:0]           seg_q, seg_d;
    logic [7:0]           len_q, len_d;
    logic [GRID_BITS-1:0] xfood_q, xfood_d;
    logic [GRID_BITS-1:0] yfood_q, yfood_d;
    logic                 self_hit_q, self_hit_d;
    logic                 food_eaten_q, food_eaten_d;
    logic                 overrun_q, overrun_d;

    logic [GRID_BITS-1:0] seg_x, seg_y;
    logic                 hit_food;

    seg_unpack u_seg_unpack (
        .snake_i (snake_in),
        .idx_i   (seg_q),
        .x_o     (seg_x),
        .y_o     (seg_y)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cell_q       <= '0;
            seg_q        <= '0;
            len_q        <= '0;
            xfood_q      <= '0;
            yfood_q      <= '0;
            self_hit_q   <= 1'b0;
            food_eaten_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cell_q       <= cell_d;
            seg_q        <= seg_d;
            len_q        <= len_d;
            xfood_q      <= xfood_d;
            yfood_q      <= yfood_d;
            self_hit_q   <= self_hit_d;
            food_eaten_q <= food_eaten_d;
            overrun_q    <= overrun_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cell_d       = cell_q;
        seg_d        = seg_q;
        len_d        = len_q;
        xfood_d      = xfood_q;
        yfood_d      = yfood_q;
        self_hit_d   = self_hit_q;
        food_eaten_d = food_eaten_q;
        overrun_d    = overrun_q;

        // wr_en depends on registered state only, never on wr_ready.
        wr_en    = 1'b0;
        wr_x     = '0;
        wr_y     = '0;
        wr_data  = CELL_EMPTY;
        hit_food = ({seg_y, seg_x} == {yfood_q, xfood_q});

        if (tick && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    len_d        = (seg_len > 8'(MAX_SEG)) ? 8'(MAX_SEG) : seg_len;
                    xfood_d      = xfood;
                    yfood_d      = yfood;
                    self_hit_d   = 1'b0;
                    food_eaten_d = 1'b0;
                    overrun_d    = 1'b0;
                    cell_d       = '0;
                    seg_d        = '0;
                    state_d      = ST_CLEAR;
                end
            end

            ST_CLEAR: begin
                wr_en   = 1'b1;
                wr_y    = cell_q[7:4];
                wr_x    = cell_q[3:0];
                wr_data = CELL_EMPTY;
                if (wr_ready) begin
                    cell_d = cell_q + 8'd1;
                    if (cell_q == 8'hFF) begin
                        cell_d  = '0;
                        seg_d   = '0;
                        state_d = (len_q == 8'd0) ? ST_FOOD : ST_SNAKE;
                    end
                end
            end

            ST_SNAKE: begin
                wr_en   = 1'b1;
                wr_x    = seg_x;
                wr_y    = seg_y;
                wr_data = (seg_q == 8'd0) ? CELL_HEAD : CELL_BODY;
                if (wr_ready) begin
                    seg_d = seg_q + 8'd1;
                    if (hit_food) begin
                        food_eaten_d = 1'b1;
                    end
                    if ((seg_q != 8'd0) && ({seg_y, seg_x} == snake_in[SEG_W-1:0])) begin
                        self_hit_d = 1'b1;
                    end
                    if (seg_q == (len_q - 8'd1)) begin
                        // Food match on the last segment must also skip FOOD,
                        // so use the combined flag rather than the register.
                        state_d = (food_eaten_q || hit_food) ? ST_DONE : ST_FOOD;
                    end
                end
            end

            ST_FOOD: begin
                if (food_eaten_q) begin
                    state_d = ST_DONE;
                end else begin
                    wr_en   = 1'b1;
                    wr_x    = xfood_q;
                    wr_y    = yfood_q;
                    wr_data = CELL_FOOD;
                    if (wr_ready) begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign self_hit   = self_hit_q;
    assign food_eaten = food_eaten_q;
    assign overrun    = overrun_q;

endmodule

// File: doc/board_update_ctrl.md
Name: board_update_ctrl

Overview:
Per-game-tick sequencer that owns the single write port of the 16x16 board memory. On each accepted tick it runs three passes in order:
- clears all 256 cells;
- writes each packed snake segment (head first) from the 1800-bit snake vector;
- writes the food cell.
Each write uses a valid/ready handshake with the memory. It also reports head self-collision and food-under-snake to the game FSM.

Parameters:
GRID_BITS, 4, bits per coordinate (board is 2^GRID_BITS square)
SEG_W, 8, bits per packed segment: y in [7:4], x in [3:0]
MAX_SEG, 225, maximum segment count; snake_in width is SEG_W*MAX_SEG = 1800

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
tick  in  1  start-of-update pulse
snake_in  in  1800  packed segments; segment i at [8i +: 8]; segment 0 is the head
seg_len  in  8  number of valid segments
xfood  in  4  food x
yfood  in  4  food y
wr_en  out  1  write request to board memory
wr_ready  in  1  memory accepts the write this cycle when high with wr_en
wr_x  out  4  write column
wr_y  out  4  write row
wr_data  out  2  cell code: 00 empty, 01 food, 10 body, 11 head
busy  out  1  high from tick acceptance until DONE
done  out  1  one-cycle pulse when the update completes
self_hit  out  1  head equals some body segment; valid from done until next accepted tick
food_eaten  out  1  food equals some segment; valid from done until next accepted tick
overrun  out  1  sticky; tick arrived while busy; cleared on next accepted tick

Behaviour:
- Reset (sync, active-high, overrides everything, including mid-pass):
  - state=IDLE; all outputs 0; counters 0.
  - A write in flight is abandoned. wr_en drops the cycle after reset is sampled.
- States: IDLE -> CLEAR -> SNAKE -> FOOD -> DONE -> IDLE.
- IDLE:
  - tick=1 latches len = min(seg_len, MAX_SEG), xfood and yfood.
  - Clears self_hit, food_eaten and overrun; sets busy; goes to CLEAR next cycle.
  - snake_in is not latched; it must be held stable while busy.
- Handshake, all write states:
  - wr_en=1 with wr_x/wr_y/wr_data stable until the cycle where wr_ready=1.
  - Counter advances only on wr_en&&wr_ready.
  - wr_ready low stalls indefinitely with no change.
  - No combinational path from wr_ready to wr_en.
- CLEAR:
  - 8-bit cell counter c, 0..255: wr_y=c[7:4], wr_x=c[3:0], wr_data=00.
  - Accepting c=255 moves to SNAKE with segment counter s=0.
  - Takes 256 accepted writes.
- SNAKE:
  - wr_y=seg[s][7:4], wr_x=seg[s][3:0]; wr_data=11 if s==0 else 10.
  - Accepting a write compares the segment to the latched food and sets food_eaten on match.
  - For s>=1, a segment equal to seg[0] sets self_hit.
  - After accepting s==len-1, go to FOOD.
  - len==0: SNAKE is skipped; CLEAR goes directly to FOOD.
- FOOD:
  - food_eaten==0: one write (xfood, yfood, 01), then DONE.
  - food_eaten==1: no write; go straight to DONE, so the snake cell is not overwritten.
- DONE: done=1 for one cycle; busy=0 from the next cycle; state returns to IDLE.
- tick while busy (including the DONE cycle): ignored and sets overrun. A tick in IDLE on the cycle after DONE is accepted.
- Latency with wr_ready tied high: tick at cycle 0 gives the first write at cycle 1; done at cycle 256+len+f+1, where f=1 if the food is written, else 0.
- Counter widths: cell counter 8 bits, must not overflow past 255 into a new pass. Segment counter 8 bits. Segment bit offset = s*8 (11 bits).

Decomposition:
- Shared package board_pkg:
  - cell codes CELL_EMPTY/FOOD/BODY/HEAD;
  - GRID_BITS, SEG_W, MAX_SEG;
  - state enum.
- Sub-module seg_unpack: combinational; index s -> (x, y) from snake_in. Isolates the wide mux.
- The FSM, handshake and flags stay in board_update_ctrl.

Test Plan:
- Reset, then tick with seg_len=3 (segments (5,5),(4,5),(3,5)), food (9,2), wr_ready=1:
  - 256 writes of 00 covering every cell once;
  - then (5,5,11), (4,5,10), (3,5,10), (9,2,01);
  - done at cycle 261; self_hit=0, food_eaten=0.
- Food (4,5) on body, seg_len=3: no food write; food_eaten=1; done at cycle 260.
- Segments (2,2),(3,2),(3,3),(2,3),(2,2): self_hit=1; head written 11, last segment written 10.
- wr_ready toggled randomly 50%:
  - address/data never change while wr_en=1 and wr_ready=0;
  - write sequence identical to the first scenario.
- tick asserted at cycles 10 and 300 during an update: both ignored, overrun=1; next tick in IDLE clears overrun. seg_len=0 gives 256 clears + food write; seg_len=250 clamps to 225 segments.
- reset asserted mid-SNAKE: wr_en=0 and busy=0 the following cycle; a new tick restarts at CLEAR cell 0.
